// File: rtl/gf251_pkg.sv
// Shared GF(251) constants and controller state encoding; no logic, no latency.
// Used by gf251_mul, gf251_add and the sequencing controllers around them.
package gf251_pkg;

    localparam int GF_Q = 251;
    localparam int GF_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FIN   = 3'd3,
        ST_ZERO  = 3'd4
    } state_t;

endpackage

// File: rtl/gf251_add.sv
// Combinational GF(251) adder, inputs must already be < 251; zero latency.
// Pure function, no flow control.
module gf251_add
    import gf251_pkg::*;
(
    input  logic [GF_W-1:0] a,
    input  logic [GF_W-1:0] b,
    output logic [GF_W-1:0] y
);

    logic [GF_W:0] s;

    always_comb begin
        s = {1'b0, a} + {1'b0, b};
        // Both inputs < q, so one conditional subtraction fully reduces.
        if (s >= (GF_W+1)'(GF_Q)) begin
            y = GF_W'(s - (GF_W+1)'(GF_Q));
        end else begin
            y = s[GF_W-1:0];
        end
    end

endmodule

// File: rtl/gf251_inner_product_ctrl.sv
// GF(251) inner product sequencer: reads len operand pairs, feeds gf251_mul, sums products.
// Latency len+M+2 from accept to o_done (M = multiplier latency); no backpressure, one pair per cycle.
module gf251_inner_product_ctrl
    import gf251_pkg::*;
#(
    parameter int N_MAX  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [ADDR_W:0]   i_len,
    output logic              o_busy,
    output logic              o_done,
    output logic [GF_W-1:0]   o_result,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [GF_W-1:0]   i_rd_a,
    input  logic [GF_W-1:0]   i_rd_b,
    output logic              o_mul_start,
    output logic [GF_W-1:0]   o_mul_a,
    output logic [GF_W-1:0]   o_mul_b,
    input  logic [GF_W-1:0]   i_mul_out,
    input  logic              i_mul_done
);

    localparam int LEN_W = ADDR_W + 1;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  rd_cnt_q;
    logic [LEN_W-1:0]  done_cnt_q;
    logic [LEN_W-1:0]  done_cnt_inc;
    logic [LEN_W-1:0]  len_clamp;
    logic [GF_W-1:0]   acc_q;
    logic [GF_W-1:0]   acc_sum;
    logic [GF_W-1:0]   result_q;
    logic              mul_start_q;
    logic              acc_en;
    logic              accept;

    gf251_add u_acc_add (
        .a (acc_q),
        .b (i_mul_out),
        .y (acc_sum)
    );

    always_comb begin
        len_clamp    = (i_len > LEN_W'(N_MAX)) ? LEN_W'(N_MAX) : i_len;
        accept       = (state_q == ST_IDLE) && i_start;
        // Products landing outside RUN/DRAIN are stale (e.g. after a reset) and dropped.
        acc_en       = i_mul_done && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
        done_cnt_inc = done_cnt_q + LEN_W'(acc_en);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        o_busy    = 1'b0;
        o_done    = 1'b0;
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = (i_len == '0) ? ST_ZERO : ST_RUN;
                end
            end
            ST_RUN: begin
                o_busy    = 1'b1;
                o_rd_en   = 1'b1;
                o_rd_addr = rd_cnt_q[ADDR_W-1:0];
                if (rd_cnt_q == len_q - LEN_W'(1)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                // Count the product arriving this cycle so FIN follows the last done directly.
                if (done_cnt_inc == len_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN, ST_ZERO: begin
                o_busy  = 1'b1;
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            len_q       <= '0;
            rd_cnt_q    <= '0;
            done_cnt_q  <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            mul_start_q <= 1'b0;
        end else begin
            mul_start_q <= o_rd_en;
            if (accept) begin
                len_q      <= len_clamp;
                rd_cnt_q   <= '0;
                done_cnt_q <= '0;
                acc_q      <= '0;
            end
            if (o_rd_en) begin
                rd_cnt_q <= rd_cnt_q + LEN_W'(1);
            end
            if (acc_en) begin
                acc_q      <= acc_sum;
                done_cnt_q <= done_cnt_inc;
            end
            if (state_d == ST_FIN) begin
                result_q <= acc_en ? acc_sum : acc_q;
            end else if (state_d == ST_ZERO) begin
                result_q <= '0;
            end
        end
    end

    always_comb begin
        o_result    = result_q;
        o_mul_start = mul_start_q;
        o_mul_a     = mul_start_q ? i_rd_a : '0;
        o_mul_b     = mul_start_q ? i_rd_b : '0;
    end

endmodule

// File: tb/tb_gf251_inner_product_ctrl.sv
// Directed bench for gf251_inner_product_ctrl with a fixed-latency multiplier and operand buffer model.
module tb_gf251_inner_product_ctrl;

    localparam int M = 3;

    typedef logic [3:0][7:0] quad_t;
    typedef struct {
        int    len;
        quad_t a;
        quad_t b;
        int    res;
    } vec_t;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [6:0] i_len = '0;
    logic       o_busy, o_done, o_rd_en, o_mul_start;
    logic [7:0] o_result, o_mul_a, o_mul_b;
    logic [5:0] o_rd_addr;
    logic [7:0] i_rd_a = '0, i_rd_b = '0;
    logic [7:0] i_mul_out;
    logic       i_mul_done;

    logic [7:0] mem_a [64];
    logic [7:0] mem_b [64];
    logic [7:0] pipe_p [M];
    logic       pipe_v [M];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mon_rd = 0, mon_ms = 0, mon_done = 0, mon_feed_err = 0, mon_addr_err = 0;
    logic       prev_rd_en = 1'b0;
    logic [5:0] prev_rd_addr = '0;
    vec_t vecs [5];

    gf251_inner_product_ctrl #(.N_MAX(64), .ADDR_W(6)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_len       (i_len),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result),
        .o_rd_en     (o_rd_en),
        .o_rd_addr   (o_rd_addr),
        .i_rd_a      (i_rd_a),
        .i_rd_b      (i_rd_b),
        .o_mul_start (o_mul_start),
        .o_mul_a     (o_mul_a),
        .o_mul_b     (o_mul_b),
        .i_mul_out   (i_mul_out),
        .i_mul_done  (i_mul_done)
    );

    always #5 i_clk = ~i_clk;

    // Operand buffer: one-cycle read latency, junk when not read.
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        if (o_rd_en) begin
            i_rd_a <= mem_a[o_rd_addr];
            i_rd_b <= mem_b[o_rd_addr];
        end else begin
            i_rd_a <= 8'hEE;
            i_rd_b <= 8'hDD;
        end
    end

    // Fixed-latency multiplier model; deliberately not reset so stale products survive a DUT reset.
    always @(posedge i_clk) begin
        pipe_v[0] <= o_mul_start;
        pipe_p[0] <= 8'((16'(o_mul_a) * 16'(o_mul_b)) % 16'd251);
        for (int i = 1; i < M; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_p[i] <= pipe_p[i-1];
        end
    end
    assign i_mul_done = pipe_v[M-1];
    assign i_mul_out  = pipe_v[M-1] ? pipe_p[M-1] : 8'hFF;

    always @(negedge i_clk) begin
        if (o_rd_en) begin
            mon_rd <= mon_rd + 1;
            if (prev_rd_en ? (o_rd_addr != prev_rd_addr + 6'd1) : (o_rd_addr != 6'd0))
                mon_addr_err <= mon_addr_err + 1;
        end
        if (o_mul_start) begin
            mon_ms <= mon_ms + 1;
            if (!prev_rd_en || o_mul_a != mem_a[prev_rd_addr] || o_mul_b != mem_b[prev_rd_addr])
                mon_feed_err <= mon_feed_err + 1;
        end else if (o_mul_a != 8'd0 || o_mul_b != 8'd0) begin
            mon_feed_err <= mon_feed_err + 1;
        end
        if (o_done) mon_done <= mon_done + 1;
        prev_rd_en   <= o_rd_en;
        prev_rd_addr <= o_rd_addr;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic quad_t pk(input logic [7:0] x0, x1, x2, x3);
        return {x3, x2, x1, x0};
    endfunction

    task automatic load(input quad_t a, input quad_t b, input logic [7:0] fill_a, input logic [7:0] fill_b);
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = fill_a;
            mem_b[i] = fill_b;
        end
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = a[i];
            mem_b[i] = b[i];
        end
    endtask

    task automatic run(input int len, input int exp_res, input int pulse_at, input string tag);
        int k, rd0, ms0, dn0, fe0, ae0, n;
        logic seen;
        n = (len > 64) ? 64 : len;
        rd0 = mon_rd; ms0 = mon_ms; dn0 = mon_done; fe0 = mon_feed_err; ae0 = mon_addr_err;
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_len = 7'(len);
        @(posedge i_clk); #1;
        i_start = 1'b0;
        k = 0;
        seen = 1'b0;
        while (k < 400 && !seen) begin
            @(negedge i_clk);
            k++;
            if (k == 1) check({tag, " busy"}, int'(o_busy), 1);
            if (k == pulse_at) begin
                i_start = 1'b1;
                i_len = 7'd5;
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                seen = 1'b1;
                check({tag, " result"}, int'(o_result), exp_res);
            end
        end
        i_start = 1'b0;
        check({tag, " done seen"}, int'(seen), 1);
        check({tag, " done cycle"}, k, (n == 0) ? 1 : n + M + 2);
        repeat (6) @(negedge i_clk);
        check({tag, " reads"}, mon_rd - rd0, n);
        check({tag, " mul starts"}, mon_ms - ms0, n);
        check({tag, " done pulses"}, mon_done - dn0, 1);
        check({tag, " feed errors"}, mon_feed_err - fe0, 0);
        check({tag, " addr errors"}, mon_addr_err - ae0, 0);
        check({tag, " result held"}, int'(o_result), exp_res);
        check({tag, " idle"}, int'(o_busy), 0);
    endtask

    initial begin
        int k, rd0, ms0, dn0;
        vecs[0] = '{len: 1, a: pk(8'd1, 8'd0, 8'd0, 8'd0),     b: pk(8'd20, 8'd0, 8'd0, 8'd0),   res: 20};
        vecs[1] = '{len: 3, a: pk(8'd1, 8'd34, 8'd62, 8'd0),   b: pk(8'd20, 8'd31, 8'd85, 8'd0), res: 69};
        vecs[2] = '{len: 2, a: pk(8'd250, 8'd250, 8'd0, 8'd0), b: pk(8'd1, 8'd1, 8'd0, 8'd0),    res: 249};
        vecs[3] = '{len: 0, a: pk(8'd9, 8'd9, 8'd9, 8'd9),     b: pk(8'd9, 8'd9, 8'd9, 8'd9),    res: 0};
        vecs[4] = '{len: 4, a: pk(8'd250, 8'd0, 8'd10, 8'd3),  b: pk(8'd250, 8'd77, 8'd25, 8'd84), res: 1};

        for (int i = 0; i < M; i++) begin
            pipe_v[i] = 1'b0;
            pipe_p[i] = '0;
        end
        load(pk(8'd0, 8'd0, 8'd0, 8'd0), pk(8'd0, 8'd0, 8'd0, 8'd0), 8'd0, 8'd0);

        repeat (3) @(negedge i_clk);
        check("rst busy", int'(o_busy), 0);
        check("rst done", int'(o_done), 0);
        check("rst rd_en", int'(o_rd_en), 0);
        check("rst rd_addr", int'(o_rd_addr), 0);
        check("rst mul_start", int'(o_mul_start), 0);
        check("rst mul_a", int'(o_mul_a), 0);
        check("rst result", int'(o_result), 0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge i_clk);

        for (int v = 0; v < 5; v++) begin
            load(vecs[v].a, vecs[v].b, 8'd0, 8'd0);
            run(vecs[v].len, vecs[v].res, 0, $sformatf("vec%0d", v));
        end

        load(pk(8'd1, 8'd1, 8'd1, 8'd1), pk(8'd1, 8'd1, 8'd1, 8'd1), 8'd1, 8'd1);
        run(64, 64, 20, "len64 restart");
        run(127, 64, 0, "len clamp");

        // Abort during DRAIN: products still in flight must not complete a result.
        load(pk(8'd5, 8'd6, 8'd7, 8'd0), pk(8'd9, 8'd9, 8'd9, 8'd0), 8'd0, 8'd0);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_len = 7'd3;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("abort result", int'(o_result), 0);
        check("abort busy", int'(o_busy), 0);
        rd0 = mon_rd; ms0 = mon_ms; dn0 = mon_done;
        k = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_busy) k++;
        end
        check("abort no done", mon_done - dn0, 0);
        check("abort no reads", mon_rd - rd0, 0);
        check("abort no starts", mon_ms - ms0, 0);
        check("abort stays idle", k, 0);
        check("abort result held", int'(o_result), 0);

        load(pk(8'd2, 8'd0, 8'd0, 8'd0), pk(8'd3, 8'd0, 8'd0, 8'd0), 8'd0, 8'd0);
        run(1, 6, 0, "post abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
